// File: rtl/div_share_ctrl.sv
// Shares one sequential 8-bit divider among NREQ requesters using a round-robin grant.
// Divide-by-zero is answered locally, and a divider that never answers is cut off after TIMEOUT wait cycles.
module div_share_ctrl #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [8*NREQ-1:0] req_dividend,
    input  logic [8*NREQ-1:0] req_divisor,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [7:0]        rsp_quotient,
    output logic [7:0]        rsp_remainder,
    output logic              rsp_overflow,
    output logic              div_start,
    output logic [7:0]        div_dividend,
    output logic [7:0]        div_divisor,
    input  logic [7:0]        div_quotient,
    input  logic [7:0]        div_remainder,
    input  logic              div_ready,
    output logic              busy,
    output logic              timeout_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [1:0]     state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] id;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] cand;
    logic           any_valid;
    logic [CW-1:0]  wait_cnt;
    logic [7:0]     dividend_u [NREQ];
    logic [7:0]     divisor_u  [NREQ];
    logic [7:0]     win_dividend;
    logic [7:0]     win_divisor;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign dividend_u[g] = req_dividend[8*g +: 8];
        assign divisor_u[g]  = req_divisor[8*g +: 8];
    end

    // Walking the rotation from the far end backwards leaves the first valid
    // requester at or after rr_ptr as the final assignment.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        winner    = rr_ptr;
        cand      = '0;
        any_valid = |req_valid;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDW'((int'(rr_ptr) + k) % NREQ);
            if (req_valid[cand]) begin
                winner = cand;
            end
        end
    end

    assign win_dividend = dividend_u[winner];
    assign win_divisor  = divisor_u[winner];

    always_comb begin
        req_ready = '0;
        if (state == IDLE && any_valid && !reset) begin
            req_ready = NREQ'(1) << winner;
        end
    end

    assign rsp_valid = (state == RESP) ? (NREQ'(1) << id) : '0;
    assign div_start = (state == ISSUE);
    assign busy      = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge value of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            id            <= '0;
            wait_cnt      <= '0;
            div_dividend  <= '0;
            div_divisor   <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_overflow  <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        id           <= winner;
                        div_dividend <= win_dividend;
                        div_divisor  <= win_divisor;
                        rr_ptr       <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
                        if (win_divisor == 8'd0) begin
                            rsp_quotient  <= 8'hFF;
                            rsp_remainder <= win_dividend;
                            rsp_overflow  <= 1'b1;
                            state         <= RESP;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (div_ready) begin
                        rsp_quotient  <= div_quotient;
                        rsp_remainder <= div_remainder;
                        rsp_overflow  <= 1'b0;
                        state         <= RESP;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        rsp_quotient  <= 8'hFF;
                        rsp_remainder <= 8'hFF;
                        rsp_overflow  <= 1'b1;
                        timeout_err   <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready[id]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Self-checking bench for div_share_ctrl: behavioural divider model, table vectors,
// corner-case sequences and randomized rounds checked against a round-level reference.
module tb_div_share_ctrl;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 32;
    localparam int DIV_LAT = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [8*NREQ-1:0] req_dividend;
    logic [8*NREQ-1:0] req_divisor;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [7:0]        rsp_quotient;
    logic [7:0]        rsp_remainder;
    logic              rsp_overflow;
    logic              div_start;
    logic [7:0]        div_dividend;
    logic [7:0]        div_divisor;
    logic [7:0]        div_quotient;
    logic [7:0]        div_remainder;
    logic              div_ready;
    logic              busy;
    logic              timeout_err;

    always #5 clk = ~clk;

    div_share_ctrl #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_quotient (rsp_quotient),
        .rsp_remainder(rsp_remainder),
        .rsp_overflow (rsp_overflow),
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_quotient (div_quotient),
        .div_remainder(div_remainder),
        .div_ready    (div_ready),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    // Divider model: drops div_ready on the start edge and answers DIV_LAT edges later unless stalled.
    logic       stall;
    logic [7:0] op_a;
    logic [7:0] op_b;
    int         dcnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            div_ready     <= 1'b0;
            div_quotient  <= '0;
            div_remainder <= '0;
            dcnt          <= 0;
        end else if (div_start) begin
            div_ready <= 1'b0;
            op_a      <= div_dividend;
            op_b      <= div_divisor;
            dcnt      <= stall ? 0 : DIV_LAT;
        end else if (dcnt == 1) begin
            div_ready     <= 1'b1;
            div_quotient  <= (op_b != 0) ? op_a / op_b : 8'h00;
            div_remainder <= (op_b != 0) ? op_a % op_b : 8'h00;
            dcnt          <= 0;
        end else if (dcnt != 0) begin
            dcnt <= dcnt - 1;
        end
    end

    int         n_checks = 0;
    int         n_fail   = 0;
    int         model_ptr;
    bit         model_terr;
    logic [7:0] dvd_arr [NREQ];
    logic [7:0] dvs_arr [NREQ];

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       ovf;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NREQ-1:0] onehot(input int i);
        return NREQ'(1) << i;
    endfunction

    function automatic int idx_of(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Reference arbiter: first valid requester in rotation order starting at model_ptr.
    function automatic int exp_winner(input logic [NREQ-1:0] mask);
        for (int k = 0; k < NREQ; k++) begin
            if (mask[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // Reference result: {overflow, quotient, remainder}.
    function automatic logic [16:0] ref_result(input logic [7:0] a, input logic [7:0] b, input bit stalled);
        if (b == 0)  return {1'b1, 8'hFF, a};
        if (stalled) return {1'b1, 16'hFFFF};
        return {1'b0, 8'(a / b), 8'(a % b)};
    endfunction

    task automatic apply_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_dividend[8*i +: 8] = dvd_arr[i];
            req_divisor[8*i +: 8]  = dvs_arr[i];
        end
    endtask

    // One grant-to-accept transaction; must be entered just after a rising edge.
    task automatic run_round(input int hold, input bit keep, output int win,
                             output logic [7:0] q, output logic [7:0] r, output logic ovf,
                             output int starts, output int grants, output int lat);
        int  held;
        bit  done;
        bit  seen;
        win = -1; starts = 0; grants = 0; lat = 0; held = 0; done = 0; seen = 0;
        q = '0; r = '0; ovf = 1'b0;
        rsp_ready = (hold == 0) ? '1 : '0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                grants++;
                if (win < 0) begin
                    win = idx_of(req_ready);
                    if (hold > 0) rsp_ready = ~onehot(win);
                end
            end
            if (div_start) starts++;
            if (rsp_valid != '0) begin
                if (!seen) begin
                    seen = 1;
                    q = rsp_quotient; r = rsp_remainder; ovf = rsp_overflow;
                    check("rsp_valid_onehot", rsp_valid, onehot(win));
                end else begin
                    check("hold.valid_stable", rsp_valid, onehot(win));
                    check("hold.data_stable", {rsp_overflow, rsp_quotient, rsp_remainder}, {ovf, q, r});
                end
                if (rsp_ready[win]) done = 1;
                else if (held < hold) held++;
                else begin
                    rsp_ready[win] = 1'b1;
                    done = 1;
                end
            end
            if (win >= 0 && !seen) lat++;
            @(posedge clk);
            #1;
            if (win >= 0 && !keep) req_valid[win] = 1'b0;
        end
        if (!done) check("round_completes", 0, 1);
    endtask

    task automatic do_round(input string tag, input int hold, input bit keep, input bit stalled,
                            output int win, output logic [7:0] q, output logic [7:0] r, output logic ovf);
        int          ew;
        int          starts;
        int          grants;
        int          lat;
        int          exp_lat;
        logic [16:0] er;
        ew      = exp_winner(req_valid);
        er      = ref_result(dvd_arr[ew], dvs_arr[ew], stalled);
        exp_lat = (dvs_arr[ew] == 0) ? 1 : (stalled ? TIMEOUT + 2 : DIV_LAT + 3);
        run_round(hold, keep, win, q, r, ovf, starts, grants, lat);
        model_ptr = (ew + 1) % NREQ;
        if (stalled && dvs_arr[ew] != 0) model_terr = 1'b1;
        check({tag, ".winner"}, win, ew);
        check({tag, ".result"}, {ovf, q, r}, er);
        check({tag, ".div_starts"}, starts, (dvs_arr[ew] != 0) ? 1 : 0);
        check({tag, ".grant_pulses"}, grants, 1);
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".busy_after"}, busy, 0);
        check({tag, ".timeout_err"}, timeout_err, model_terr);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int               win;
        logic [7:0]       q;
        logic [7:0]       r;
        logic             ovf;
        logic [NREQ-1:0]  m;
        int               g;
        bit               seen_start;

        reset = 1'b1; stall = 1'b0;
        req_valid = '0; rsp_ready = '0; req_dividend = '0; req_divisor = '0;
        model_ptr = 0; model_terr = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.outputs", {req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_overflow,
                                div_start, div_dividend, div_divisor, busy, timeout_err}, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // All four requesters held valid with responses always accepted: strict rotation.
        dvd_arr = '{8'd255, 8'd100, 8'd81, 8'd13};
        dvs_arr = '{8'd16,  8'd7,   8'd9,  8'd200};
        apply_ops();
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            do_round("rr", 0, 1, 0, win, q, r, ovf);
            check("rr.order", win, k % NREQ);
        end
        req_valid = '0;

        vecs[0] = '{1, 8'd100, 8'd7,   8'd14,  8'd2,   1'b0};
        vecs[1] = '{2, 8'd200, 8'd0,   8'hFF,  8'd200, 1'b1};
        vecs[2] = '{0, 8'd255, 8'd16,  8'd15,  8'd15,  1'b0};
        vecs[3] = '{3, 8'd9,   8'd3,   8'd3,   8'd0,   1'b0};
        vecs[4] = '{0, 8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
        vecs[5] = '{1, 8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
        vecs[6] = '{2, 8'd7,   8'd200, 8'd0,   8'd7,   1'b0};
        vecs[7] = '{3, 8'd1,   8'd0,   8'hFF,  8'd1,   1'b1};
        for (int v = 0; v < 8; v++) begin
            dvd_arr[vecs[v].id] = vecs[v].a;
            dvs_arr[vecs[v].id] = vecs[v].b;
            apply_ops();
            req_valid = onehot(vecs[v].id);
            do_round("vec", 0, 0, 0, win, q, r, ovf);
            check("vec.table_result", {ovf, q, r}, {vecs[v].ovf, vecs[v].q, vecs[v].r});
        end

        // Backpressure: response held 5 cycles while another requester waits.
        dvd_arr[0] = 8'd50; dvs_arr[0] = 8'd6;
        dvd_arr[1] = 8'd60; dvs_arr[1] = 8'd7;
        apply_ops();
        req_valid = 4'b0011;
        do_round("bp", 5, 0, 0, win, q, r, ovf);
        do_round("bp_next", 0, 0, 0, win, q, r, ovf);

        // Stalled divider: timeout, then timeout_err stays set across a good operation.
        stall = 1'b1;
        dvd_arr[3] = 8'd45; dvs_arr[3] = 8'd9;
        apply_ops();
        req_valid = onehot(3);
        do_round("tmo", 0, 0, 1, win, q, r, ovf);
        stall = 1'b0;
        req_valid = onehot(3);
        do_round("after_tmo", 0, 0, 0, win, q, r, ovf);
        check("after_tmo.q", q, 8'd5);

        // Randomized rounds against the reference.
        for (int t = 0; t < 40; t++) begin
            m = NREQ'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) begin
                dvd_arr[i] = 8'($urandom_range(0, 255));
                dvs_arr[i] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            end
            apply_ops();
            req_valid = m;
            if (m == '0) begin
                g = 0;
                repeat (3) begin
                    @(negedge clk);
                    if (req_ready != '0 || busy) g++;
                end
                check("rnd.idle_no_grant", g, 0);
                @(posedge clk);
                #1;
            end else begin
                do_round("rnd", int'($urandom_range(0, 3)), 0, 0, win, q, r, ovf);
            end
        end
        req_valid = '0;

        // Reset in the middle of WAIT after granting requester 2.
        dvd_arr[2] = 8'd90; dvs_arr[2] = 8'd9;
        apply_ops();
        req_valid = onehot(2);
        seen_start = 1'b0;
        for (int c = 0; c < 20 && !seen_start; c++) begin
            @(negedge clk);
            if (div_start) seen_start = 1'b1;
        end
        check("rst.start_seen", seen_start, 1);
        repeat (3) @(negedge clk);
        check("rst.busy_before", busy, 1);
        reset = 1'b1;
        #1;
        check("rst.outputs_zero", {req_ready, rsp_valid, rsp_quotient, rsp_remainder, rsp_overflow,
                                   div_start, div_dividend, div_divisor, busy, timeout_err}, 0);
        req_valid = '0;
        model_ptr = 0;
        model_terr = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        dvd_arr[0] = 8'd9;  dvs_arr[0] = 8'd3;
        dvd_arr[3] = 8'd50; dvs_arr[3] = 8'd5;
        apply_ops();
        req_valid = 4'b1001;
        do_round("post_rst", 0, 0, 0, win, q, r, ovf);
        check("post_rst.winner0", win, 0);
        check("post_rst.result", {ovf, q, r}, {1'b0, 8'd3, 8'd0});
        req_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
- Controller that shares one 8-bit sequential non-restoring divider among NREQ requesters.
- Arbitrates round-robin, latches the winner's operands and pulses the divider start.
- Waits for divider completion, then returns quotient, remainder and overflow to the winner over a valid/ready response channel.
- Handles divide-by-zero locally and guards against a hung divider with a timeout. Sits between client blocks and the divider instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester index width, equal to ceil(log2(NREQ)).
- TIMEOUT, 32, max cycles waiting for div_ready before the operation is aborted.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  one-hot accept pulse.
- req_dividend  in  8*NREQ  packed dividends; requester i is in [8i+7:8i].
- req_divisor  in  8*NREQ  packed divisors, same packing.
- rsp_valid  out  NREQ  one-hot response valid to the granted requester.
- rsp_ready  in  NREQ  per-requester response accept.
- rsp_quotient  out  8  result quotient.
- rsp_remainder  out  8  result remainder.
- rsp_overflow  out  1  set for divide-by-zero or timeout.
- div_start  out  1  one-cycle start pulse to the divider.
- div_dividend  out  8  operand to the divider, held from ISSUE until return to IDLE.
- div_divisor  out  8  operand to the divider, held from ISSUE until return to IDLE.
- div_quotient  in  8  divider result.
- div_remainder  in  8  divider result.
- div_ready  in  1  divider done level; cleared by the divider on the edge that samples div_start.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky; set on any timeout; cleared only by reset.

Behaviour:
- Reset (asynchronous, any state, including mid-division):
  - All outputs 0, state IDLE, rr_ptr=0, wait counter 0, latched operands and id 0.
  - The divider shares the same reset.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, when any req_valid is high:
  - Winner = first set bit searching from rr_ptr upward, wrapping modulo NREQ.
  - req_ready[winner]=1 for exactly this cycle (combinational from state and req_valid; 0 outside IDLE).
  - Latch the winner's operands and id. rr_ptr <= winner+1, wrapping NREQ-1 -> 0.
  - If divisor==0: load result quotient=8'hFF, remainder=dividend, overflow=1; go to RESP with no div_start.
  - Otherwise go to ISSUE.
  - No req_valid: remain in IDLE, all req_ready low.
- ISSUE: div_start=1 for this single cycle; clear the wait counter; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - div_ready==1: capture div_quotient and div_remainder, overflow=0, go to RESP.
  - Counter reaches TIMEOUT-1 without div_ready: result 8'hFF/8'hFF, overflow=1, timeout_err<=1, go to RESP.
  - div_ready is low throughout the first WAIT cycle by divider construction, so no stale completion is accepted.
- RESP:
  - rsp_valid[id]=1; rsp_quotient, rsp_remainder and rsp_overflow are registered and stable.
  - On rsp_ready[id]==1: go to IDLE; rsp_valid drops next cycle.
  - rsp_ready of other requesters is ignored.
  - Backpressure is unlimited: no new grant while in RESP.
- Throughput: a new request can be granted in the cycle after leaving RESP. div_start is never asserted outside ISSUE.
- Nominal latency, grant to rsp_valid: 1 (ISSUE) + divider latency (about 11 cycles) + 1.
- A request withdrawn before its grant is simply not served. The arbiter is not sticky.
- Simultaneous requests: exactly one grant per IDLE visit. A requester granted in one round has lowest priority in the next round.

Test Plan:
- Requester 1 only, 100/7 -> req_ready[1] one cycle, single div_start, rsp_valid[1] with q=14, r=2, overflow=0; busy low after accept.
- Requester 2, 200/0 -> no div_start, rsp_valid[2] with q=8'hFF, r=200, overflow=1, timeout_err stays 0.
- All four requesters held valid, rsp_ready tied high -> grants in order 0,1,2,3,0; each result matches its operands (e.g. 255/16 -> q=15, r=15).
- rsp_ready held low for 5 cycles in RESP while another requester is valid -> rsp_valid and data stable for all 5 cycles, no req_ready, no div_start.
- div_ready forced 0 (divider model stalled) -> after TIMEOUT cycles in WAIT, rsp_valid with q=r=8'hFF, overflow=1, timeout_err=1 sticky across later good operations.
- Assert reset during WAIT -> all outputs 0 immediately; after release, a new 9/3 request returns q=3, r=0 and rr_ptr restarts at 0.
